// File: rtl/parallel_to_serial.sv
// parallel_to_serial
//   Serialises WIDTH-bit words onto a one-bit valid/ready stream, LSB first.
//   One active word sits in the shift register and one pending word can
//   wait in the holding register, so words stream back-to-back without gaps.
//
//   Optional feature: define PARALLEL_TO_SERIAL_PARITY_EN to append one even
//   parity bit (XOR of the data bits) after each word's last data bit.
//
// Ports
//   clk             clock, rising edge
//   rst             asynchronous reset, active low
//   parallel_valid  upstream word present
//   parallel_data   upstream word [WIDTH-1:0]
//   parallel_ready  holding register empty (0 while rst low)
//   serial_valid    serial_data holds a valid bit
//   serial_data     current serial bit (0 when serial_valid low)
//   serial_ready    downstream accepts the bit this cycle
//   busy            shifter or holding register occupied
//
// state  | meaning
// IDLE   | shifter empty, no bit on the serial side
// SHIFT  | data bits of the active word in flight
// PARITY | parity bit of the active word in flight (macro builds only)

module parallel_to_serial #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             parallel_valid,
   input  logic [WIDTH-1:0] parallel_data,
   output logic             parallel_ready,
   output logic             serial_valid,
   output logic             serial_data,
   input  logic             serial_ready,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);

`ifdef PARALLEL_TO_SERIAL_PARITY_EN
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] shift_q;
   logic [WIDTH-1:0] hold_q;
   logic             hold_full;
   logic [CW-1:0]    cnt;
   logic             accept;
   logic             xfer;
   logic             last_data;
   logic             word_done;
   logic             load_shift;
   logic [WIDTH-1:0] load_data;
`ifdef PARALLEL_TO_SERIAL_PARITY_EN
   logic             par_q;
`endif

   assign accept    = parallel_valid && parallel_ready;
   assign xfer      = serial_valid && serial_ready;
   assign last_data = (state == SHIFT) && (cnt == CW'(WIDTH - 1)) && xfer;
`ifdef PARALLEL_TO_SERIAL_PARITY_EN
   assign word_done = (state == PARITY) && xfer;
`else
   assign word_done = last_data;
`endif

   // The pending word has priority when the active word finishes; while it
   // is pending parallel_ready is low, so no acceptance can collide with it.
   assign load_shift = ((state == IDLE) && accept) || (word_done && (hold_full || accept));
   assign load_data  = hold_full ? hold_q : parallel_data;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) state_nxt = SHIFT;
         end
         SHIFT: begin
`ifdef PARALLEL_TO_SERIAL_PARITY_EN
            if (last_data) state_nxt = PARITY;
`else
            if (last_data) state_nxt = (hold_full || accept) ? SHIFT : IDLE;
`endif
         end
`ifdef PARALLEL_TO_SERIAL_PARITY_EN
         PARITY: begin
            if (xfer) state_nxt = (hold_full || accept) ? SHIFT : IDLE;
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   // parallel_ready depends only on registered state and the reset pin, so
   // there is no path from serial_ready or parallel_valid.
   always_comb begin
      parallel_ready = rst && !hold_full;
      serial_valid   = (state != IDLE);
      busy           = (state != IDLE) || hold_full;
      serial_data    = 1'b0;
      case (state)
         SHIFT:   serial_data = shift_q[0];
`ifdef PARALLEL_TO_SERIAL_PARITY_EN
         PARITY:  serial_data = par_q;
`endif
         default: serial_data = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift_q   <= '0;
         hold_q    <= '0;
         hold_full <= 1'b0;
         cnt       <= '0;
`ifdef PARALLEL_TO_SERIAL_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         if (load_shift) begin
            shift_q <= load_data;
            cnt     <= '0;
`ifdef PARALLEL_TO_SERIAL_PARITY_EN
            par_q   <= ^load_data;
`endif
         end else if (xfer && (state == SHIFT)) begin
            shift_q <= shift_q >> 1;
            cnt     <= cnt + CW'(1);
         end

         if (word_done && hold_full) begin
            hold_full <= 1'b0;
         end else if (accept && !load_shift) begin
            hold_q    <= parallel_data;
            hold_full <= 1'b1;
         end
      end
   end

endmodule

// File: doc/parallel_to_serial.md
PARALLEL_TO_SERIAL -- requirements
Module: parallel_to_serial

Interface
REQ-001 Parameter: WIDTH, default 8, number of bits per parallel word (WIDTH >= 2).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 parallel_valid  input  1  upstream word present.
REQ-005 parallel_data  input  WIDTH  upstream word.
REQ-006 parallel_ready  output  1  block can accept a word this cycle.
REQ-007 serial_valid  output  1  serial_data holds a valid bit.
REQ-008 serial_data  output  1  current serial bit.
REQ-009 serial_ready  input  1  downstream accepts bit this cycle.
REQ-010 busy  output  1  shifter or holding register occupied.

Function
REQ-011 Word accepted on a rising edge where parallel_valid && parallel_ready; bit transferred on a rising edge where serial_valid && serial_ready.
REQ-012 Bit order LSB first: parallel_data[0] is the first serial bit, [WIDTH-1] the last data bit, matching the downstream serial_to_parallel packing.
REQ-013 Storage: one shift register (active word) plus one holding register (pending word).
REQ-014 States: IDLE (shifter empty), SHIFT (data bits in flight), PARITY (only with macro, see REQ-024).
REQ-015 IDLE -> SHIFT on acceptance; serial_valid high and serial_data = bit 0 in the cycle after the accepting edge (latency 1).
REQ-016 SHIFT: bit counter (width $clog2(WIDTH+1)) advances only on transfer; after last bit transfer -> SHIFT with pending word if holding full, else IDLE (or PARITY with macro).
REQ-017 Acceptance on the same edge as the final bit transfer loads the new word directly into the shifter; no idle cycle between words when serial_ready is held high.
REQ-018 Acceptance while shifter busy and not finishing loads the holding register.
REQ-019 parallel_ready = holding register empty; registered, no combinational path from serial_ready or parallel_valid.
REQ-020 serial_valid and serial_data SHALL NOT depend combinationally on serial_ready; while serial_valid && !serial_ready both stay stable.
REQ-021 Holding register full and final bit transferred on same edge: pending word moves to shifter; parallel_ready rises in following cycle.
REQ-022 busy = (state != IDLE) || holding full.
REQ-023 parallel_data ignored when not accepted; serial_data undefined-free (drive 0) when serial_valid low.

Configuration
REQ-024 Macro PARALLEL_TO_SERIAL_PARITY_EN defined: after each word's last data bit, one extra serial bit = even parity (XOR of the WIDTH data bits) in state PARITY; word occupies WIDTH+1 serial transfers; back-to-back rule of REQ-017 applies to parity-bit transfer.
REQ-025 Macro undefined: PARITY state and parity logic absent; word occupies exactly WIDTH serial transfers.

Reset
REQ-026 rst low: state IDLE, counter 0, holding empty, shifter 0; outputs parallel_ready=1 only after rst deasserts (0 while rst low), serial_valid=0, serial_data=0, busy=0.
REQ-027 Reset mid-word discards active and pending words; no partial word resumes after reset.
REQ-028 First acceptance possible on the first rising edge after rst deasserts.

Verification
REQ-029 WIDTH=8, serial_ready=1, single word 8'hA5 -> serial bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting one cycle after accept; then serial_valid=0, busy=0.
REQ-030 Back-to-back 8'h01, 8'hFF, 8'h80 with parallel_valid held high, serial_ready=1 -> 24 contiguous valid bits, no gaps; parallel_ready never low more than one word-time.
REQ-031 serial_ready toggled random 50% over 100 random words -> bench queue reassembles identical words in order; serial_data stable during stalls; total transfers = 800.
REQ-032 serial_ready=0 permanently, offer 3 words -> words 1 and 2 accepted, parallel_ready=0 from then, third word not accepted, busy=1.
REQ-033 rst asserted after 3 bits of 8'h3C with holding full -> serial_valid=0 immediately; after release, new word 8'h0F emits 1,1,1,1,0,0,0,0 only.
REQ-034 With PARALLEL_TO_SERIAL_PARITY_EN, words 8'h07 then 8'h03 -> 9 bits each, parity bits 1 then 0; without macro same stimulus -> 16 bits total.
